pc_next_ctrl: RTL

//   Owns the program counter and drives the PC-source selection for the
//   3-input next-PC mux (0 = PC+4, 1 = {PC+4[31:28], jump field}, 2 = branch/

---
 rtl/pc_next_ctrl.sv | 86 ++++++++
 1 files changed

// File: rtl/pc_next_ctrl.sv
// IF-stage program counter owner: next-PC selection, stall/redirect handling,
// wrong-path flush sequencing and a saturating redirect counter.
module pc_next_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic [31:0]      BranchTarget,
  input  logic             JumpEn,
  input  logic [25:0]      JumpIdx,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic [3:0]       PCTop4,
  output logic [27:0]      JumpAddr28,
  output logic [1:0]       PCSel,
  output logic             FetchValid,
  output logic             Flush,
  output logic [CNT_W-1:0] RedirectCnt
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

  state_t      state;
  logic        redirect;
  logic [31:0] pc_next;
  logic        unused_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign PCPlus4     = PC + 32'd4;
  assign PCTop4      = PCPlus4[31:28];
  assign JumpAddr28  = {JumpIdx, 2'b00};
  assign redirect    = BranchEn | JumpEn;
  assign unused_bits = ^BranchTarget[1:0];

  always_comb begin
    PCSel = 2'd0;
    if (BranchEn)    PCSel = 2'd2;
    else if (JumpEn) PCSel = 2'd1;
  end

  // Branch targets are word-aligned by forcing the low bits to zero.
  always_comb begin
    pc_next = PCPlus4;
    case (PCSel)
      2'd2:    pc_next = {BranchTarget[31:2], 2'b00};
      2'd1:    pc_next = {PCTop4, JumpAddr28};
      default: pc_next = PCPlus4;
    endcase
  end

  // Stage p0: PC register and fetch-slot state; a redirect always wins over Stall.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      PC          <= RESET_PC;
      state       <= S_BOOT;
      Flush       <= 1'b0;
      FetchValid  <= 1'b0;
      RedirectCnt <= '0;
    end else begin
      if (redirect || !Stall)
        PC <= pc_next;
      if (redirect)
        RedirectCnt <= sat_inc(RedirectCnt);
      if (redirect) begin
        state      <= S_FLUSH;
        Flush      <= 1'b1;
        FetchValid <= 1'b0;
      end else if (state == S_BOOT && Stall) begin
        state      <= S_BOOT;
        Flush      <= 1'b0;
        FetchValid <= 1'b0;
      end else begin
        state      <= S_RUN;
        Flush      <= 1'b0;
        FetchValid <= 1'b1;
      end
    end
  end

endmodule
